// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin arbiter sharing one stack unit between two clients,
// with per-client request queuing (depth 1) and a wait-for-ack timeout.
module stack_arbiter #(
   parameter int DW  = 32,
   parameter int NW  = 10,
   parameter int OPW = 3,
   parameter int TMO = 1023
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic           c0_rdy,
   input  logic [OPW-1:0] c0_op,
   input  logic [DW-1:0]  c0_datain,
   input  logic [NW-1:0]  c0_n,
   input  logic           c1_rdy,
   input  logic [OPW-1:0] c1_op,
   input  logic [DW-1:0]  c1_datain,
   input  logic [NW-1:0]  c1_n,
   output logic           c0_ack,
   output logic [DW-1:0]  c0_dataout,
   output logic           c0_esito,
   output logic           c0_tmo,
   output logic           c1_ack,
   output logic [DW-1:0]  c1_dataout,
   output logic           c1_esito,
   output logic           c1_tmo,
   output logic           s_rdy,
   output logic [OPW-1:0] s_op,
   output logic [DW-1:0]  s_datain,
   output logic [NW-1:0]  s_n,
   input  logic           s_ack,
   input  logic [DW-1:0]  s_dataout,
   input  logic           s_esito,
   output logic           busy,
   output logic           grant
);
   localparam int CW = $clog2(TMO + 1);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   logic [1:0]     rdy;
   logic [OPW-1:0] in_op   [2];
   logic [DW-1:0]  in_din  [2];
   logic [NW-1:0]  in_n    [2];

   logic [1:0]     state_q, state_d;
   logic [1:0]     pend_q, pend_d;
   logic           last_q, last_d;
   logic           grant_q, grant_d;
   logic           busy_q, busy_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [OPW-1:0] rop_q   [2];
   logic [OPW-1:0] rop_d   [2];
   logic [DW-1:0]  rdin_q  [2];
   logic [DW-1:0]  rdin_d  [2];
   logic [NW-1:0]  rn_q    [2];
   logic [NW-1:0]  rn_d    [2];
   logic           s_rdy_q, s_rdy_d;
   logic [OPW-1:0] s_op_q, s_op_d;
   logic [DW-1:0]  s_din_q, s_din_d;
   logic [NW-1:0]  s_n_q, s_n_d;
   logic [1:0]     ack_q, ack_d;
   logic [DW-1:0]  dout_q  [2];
   logic [DW-1:0]  dout_d  [2];
   logic [1:0]     esito_q, esito_d;
   logic [1:0]     tmo_q, tmo_d;
   logic           sel;

   assign rdy       = {c1_rdy, c0_rdy};
   assign in_op[0]  = c0_op;
   assign in_op[1]  = c1_op;
   assign in_din[0] = c0_datain;
   assign in_din[1] = c1_datain;
   assign in_n[0]   = c0_n;
   assign in_n[1]   = c1_n;

   // on a tie the client that was not served last wins
   assign sel = &pend_q ? ~last_q : pend_q[1];

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      last_d  = last_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      rop_d   = rop_q;
      rdin_d  = rdin_q;
      rn_d    = rn_q;
      s_rdy_d = 1'b0;
      s_op_d  = s_op_q;
      s_din_d = s_din_q;
      s_n_d   = s_n_q;
      ack_d   = '0;
      dout_d  = dout_q;
      esito_d = esito_q;
      tmo_d   = tmo_q;
      for (int i = 0; i < 2; i++)
         if (rdy[i] && !pend_q[i]) begin
            pend_d[i] = 1'b1;
            rop_d[i]  = in_op[i];
            rdin_d[i] = in_din[i];
            rn_d[i]   = in_n[i];
         end
      case (state_q)
         IDLE:
            if (|pend_q) begin
               grant_d     = sel;
               pend_d[sel] = 1'b0;
               s_rdy_d     = 1'b1;
               s_op_d      = rop_q[sel];
               s_din_d     = rdin_q[sel];
               s_n_d       = rn_q[sel];
               state_d     = ISSUE;
            end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT:
            // an ack landing on the last timeout cycle still counts as a real completion
            if (s_ack || cnt_q == CW'(TMO - 1)) begin
               dout_d[grant_q]  = s_ack ? s_dataout : '0;
               esito_d[grant_q] = s_ack & s_esito;
               tmo_d[grant_q]   = ~s_ack;
               ack_d[grant_q]   = 1'b1;
               state_d          = RESP;
            end else
               cnt_d = cnt_q + CW'(1);
         default: begin
            last_d  = grant_q;
            state_d = IDLE;
         end
      endcase
      busy_d = state_d != IDLE;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= IDLE;
         pend_q  <= '0;
         last_q  <= 1'b1;
         grant_q <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         rop_q   <= '{default: '0};
         rdin_q  <= '{default: '0};
         rn_q    <= '{default: '0};
         s_rdy_q <= 1'b0;
         s_op_q  <= '0;
         s_din_q <= '0;
         s_n_q   <= '0;
         ack_q   <= '0;
         dout_q  <= '{default: '0};
         esito_q <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         rop_q   <= rop_d;
         rdin_q  <= rdin_d;
         rn_q    <= rn_d;
         s_rdy_q <= s_rdy_d;
         s_op_q  <= s_op_d;
         s_din_q <= s_din_d;
         s_n_q   <= s_n_d;
         ack_q   <= ack_d;
         dout_q  <= dout_d;
         esito_q <= esito_d;
         tmo_q   <= tmo_d;
      end
   end

   assign c0_ack     = ack_q[0];
   assign c1_ack     = ack_q[1];
   assign c0_dataout = dout_q[0];
   assign c1_dataout = dout_q[1];
   assign c0_esito   = esito_q[0];
   assign c1_esito   = esito_q[1];
   assign c0_tmo     = tmo_q[0];
   assign c1_tmo     = tmo_q[1];
   assign s_rdy      = s_rdy_q;
   assign s_op       = s_op_q;
   assign s_datain   = s_din_q;
   assign s_n        = s_n_q;
   assign busy       = busy_q;
   assign grant      = grant_q;
endmodule
